// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Requests are accepted over valid/ready with round-robin arbitration, the
// ALU is driven from registered operands for one EXEC cycle, and the
// registered result is returned to the granted requester.
// Optional feature macro: ALU_OPCHECK_EN (illegal ctrl codes are replaced by
// 0000 at the ALU and answered with result=0, zero=1, err=1).
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int CTRLW = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [CTRLW-1:0] req0_ctrl,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [CTRLW-1:0] req1_ctrl,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic             rsp0_zero,
   output logic             rsp0_err,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic             rsp1_zero,
   output logic             rsp1_err,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [CTRLW-1:0] alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_reg, state_next;
   logic             last_grant_reg;
   logic             grant_reg;
   logic [WIDTH-1:0] a_reg, b_reg, result_reg;
   logic [CTRLW-1:0] ctrl_reg;
   logic             zero_reg;

   logic             win;
   logic             accept;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [CTRLW-1:0] sel_ctrl;
   logic             rsp_take;

`ifdef ALU_OPCHECK_EN
   logic illegal_reg;
   logic err_reg;
   logic illegal_in;

   // Classify the incoming ctrl code against the set the ALU implements.
   always_comb begin
      illegal_in = 1'b1;
      if (sel_ctrl == CTRLW'(4'b0000) || sel_ctrl == CTRLW'(4'b0001) ||
          sel_ctrl == CTRLW'(4'b0010) || sel_ctrl == CTRLW'(4'b0110) ||
          sel_ctrl == CTRLW'(4'b0111) || sel_ctrl == CTRLW'(4'b1100))
         illegal_in = 1'b0;
   end

   assign alu_ctrl = illegal_reg ? '0 : ctrl_reg;
   assign rsp0_err = err_reg;
   assign rsp1_err = err_reg;
`else
   assign alu_ctrl = ctrl_reg;
   assign rsp0_err = 1'b0;
   assign rsp1_err = 1'b0;
`endif

   // ALU operands come only from the latched registers, so they hold outside EXEC.
   assign alu_a = a_reg;
   assign alu_b = b_reg;

   assign rsp0_valid  = (state_reg == RESP) && !grant_reg;
   assign rsp1_valid  = (state_reg == RESP) &&  grant_reg;
   assign rsp0_result = result_reg;
   assign rsp1_result = result_reg;
   assign rsp0_zero   = zero_reg;
   assign rsp1_zero   = zero_reg;

   // Arbitration, handshake and next-state logic; a tie goes to the requester not granted last.
   always_comb begin
      win        = 1'b0;
      accept     = 1'b0;
      rsp_take   = 1'b0;
      state_next = state_reg;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (req0_valid && req1_valid)
         win = ~last_grant_reg;
      else if (req1_valid)
         win = 1'b1;
      sel_a    = win ? req1_a    : req0_a;
      sel_b    = win ? req1_b    : req0_b;
      sel_ctrl = win ? req1_ctrl : req0_ctrl;
      case (state_reg)
         IDLE: begin
            if (!rst && (req0_valid || req1_valid)) begin
               accept     = 1'b1;
               req0_ready = !win;
               req1_ready = win;
               state_next = EXEC;
            end
         end
         EXEC: state_next = RESP;
         RESP: begin
            rsp_take = grant_reg ? rsp1_ready : rsp0_ready;
            if (rsp_take)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State, operand latch on acceptance and result capture at the end of EXEC.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         grant_reg      <= 1'b0;
         a_reg          <= '0;
         b_reg          <= '0;
         ctrl_reg       <= '0;
         result_reg     <= '0;
         zero_reg       <= 1'b0;
`ifdef ALU_OPCHECK_EN
         illegal_reg    <= 1'b0;
         err_reg        <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         if (accept) begin
            a_reg          <= sel_a;
            b_reg          <= sel_b;
            ctrl_reg       <= sel_ctrl;
            grant_reg      <= win;
            last_grant_reg <= win;
`ifdef ALU_OPCHECK_EN
            illegal_reg    <= illegal_in;
`endif
         end
         if (state_reg == EXEC) begin
`ifdef ALU_OPCHECK_EN
            result_reg <= illegal_reg ? '0 : alu_result;
            zero_reg   <= illegal_reg | alu_zero;
            err_reg    <= illegal_reg;
`else
            result_reg <= alu_result;
            zero_reg   <= alu_zero;
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

   localparam int WIDTH = 32;
   localparam int CTRLW = 4;

   logic             clk;
   logic             rst;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [CTRLW-1:0] req0_ctrl, req1_ctrl;
   logic             rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
   logic             rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
   logic [WIDTH-1:0] rsp0_result, rsp1_result;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result;
   logic [CTRLW-1:0] alu_ctrl;
   logic             alu_zero;

   int checks = 0;
   int errors = 0;

   alu_arbiter #(.WIDTH(WIDTH), .CTRLW(CTRLW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ALU stand-in.
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: alu_result = alu_a + alu_b;
         4'b0110: alu_result = alu_a - alu_b;
         4'b0111: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
         4'b1100: alu_result = ~alu_a;
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe();
      @(negedge clk);
   endtask

   task automatic test_reset();
      tick();
      req0_valid = 1'b1; req1_valid = 1'b1;
      probe();
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %0h expected 0", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %0h expected 0", req1_ready); end
      checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b%0b expected 00", rsp0_valid, rsp1_valid); end
      checks++; if (rsp0_err !== 1'b0 || rsp1_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %0b%0b expected 00", rsp0_err, rsp1_err); end
      checks++; if (rsp0_result !== 32'h0 || rsp0_zero !== 1'b0) begin errors++; $display("FAIL reset_result: got %0h/%0b expected 0/0", rsp0_result, rsp0_zero); end
      checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_ctrl !== 4'h0) begin errors++; $display("FAIL reset_alu_regs: got %0h %0h %0h expected 0 0 0", alu_a, alu_b, alu_ctrl); end
      tick();
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      probe();
      $display("reset released");
   endtask

   task automatic test_single_op();
      tick();
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 4'b0010;
      probe();
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_req0_ready: got %0h expected 1", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_req1_ready: got %0h expected 0", req1_ready); end
      tick();
      req0_valid = 1'b0;
      probe();
      checks++; if (alu_ctrl !== 4'b0010 || alu_a !== 32'd5 || alu_b !== 32'd3) begin errors++; $display("FAIL single_exec_alu: got %0h %0h %0h expected 2 5 3", alu_ctrl, alu_a, alu_b); end
      checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0h expected 0", rsp0_valid); end
      tick();
      rsp0_ready = 1'b1;
      probe();
      checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_valid: got %0b%0b expected 10", rsp0_valid, rsp1_valid); end
      checks++; if (rsp0_result !== 32'd8 || rsp0_zero !== 1'b0 || rsp0_err !== 1'b0) begin errors++; $display("FAIL single_rsp_data: got %0h/%0b/%0b expected 8/0/0", rsp0_result, rsp0_zero, rsp0_err); end
      $display("single op: rsp0 result=%0h zero=%0b err=%0b", rsp0_result, rsp0_zero, rsp0_err);
      tick();
      rsp0_ready = 1'b0;
      probe();
      checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %0h expected 0", rsp0_valid); end
   endtask

   task automatic test_zero_flag();
      tick();
      req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7; req1_ctrl = 4'b0110;
      probe();
      checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL zero_ready: got %0b%0b expected 01", req0_ready, req1_ready); end
      tick();
      req1_valid = 1'b0;
      probe();
      checks++; if (rsp0_valid !== 1'b0 || alu_ctrl !== 4'b0110) begin errors++; $display("FAIL zero_exec: got %0b/%0h expected 0/6", rsp0_valid, alu_ctrl); end
      tick();
      rsp1_ready = 1'b1;
      probe();
      checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL zero_rsp_valid: got %0b%0b expected 01", rsp0_valid, rsp1_valid); end
      checks++; if (rsp1_result !== 32'd0 || rsp1_zero !== 1'b1) begin errors++; $display("FAIL zero_rsp_data: got %0h/%0b expected 0/1", rsp1_result, rsp1_zero); end
      $display("zero flag: rsp1 result=%0h zero=%0b", rsp1_result, rsp1_zero);
      tick();
      rsp1_ready = 1'b0;
      probe();
      checks++; if (rsp1_valid !== 1'b0 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL zero_rsp_drop: got %0b%0b expected 00", rsp0_valid, rsp1_valid); end
   endtask

   task automatic test_contention();
      logic [WIDTH-1:0] exp_res;
      logic             exp_id;
      tick();
      rst = 1'b1;
      probe();
      tick();
      rst = 1'b0;
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 4'b0111;
      req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'd5; req1_ctrl = 4'b1100;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      probe();
      for (int k = 0; k < 4; k++) begin
         exp_id  = k[0];
         exp_res = exp_id ? 32'hFFFF_FFFF : 32'd1;
         checks++; if (req0_ready !== !exp_id || req1_ready !== exp_id) begin errors++; $display("FAIL contention_grant%0d: got %0b%0b expected id %0d", k, req0_ready, req1_ready, exp_id); end
         tick(); probe();
         checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL contention_exec_ready%0d: got %0b%0b expected 00", k, req0_ready, req1_ready); end
         tick(); probe();
         checks++; if (rsp0_valid !== !exp_id || rsp1_valid !== exp_id) begin errors++; $display("FAIL contention_rsp_valid%0d: got %0b%0b expected id %0d", k, rsp0_valid, rsp1_valid, exp_id); end
         checks++; if ((exp_id ? rsp1_result : rsp0_result) !== exp_res) begin errors++; $display("FAIL contention_result%0d: got %0h expected %0h", k, exp_id ? rsp1_result : rsp0_result, exp_res); end
         $display("contention %0d: id=%0d result=%0h", k, exp_id, exp_id ? rsp1_result : rsp0_result);
         if (k < 3) begin
            tick(); probe();
         end
      end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      probe();
   endtask

   task automatic test_backpressure();
      tick();
      req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4; req0_ctrl = 4'b0110;
      req1_valid = 1'b1; req1_a = 32'd3;  req1_b = 32'd12; req1_ctrl = 4'b0001;
      probe();
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_grant: got %0b%0b expected 10", req0_ready, req1_ready); end
      tick();
      req0_valid = 1'b0; rsp1_ready = 1'b1;
      probe();
      for (int i = 0; i < 5; i++) begin
         tick(); probe();
         checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd6) begin errors++; $display("FAIL bp_hold%0d: got %0b/%0h expected 1/6", i, rsp0_valid, rsp0_result); end
         checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %0b%0b expected 00", i, req0_ready, req1_ready); end
      end
      $display("backpressure: rsp0 held result=%0h", rsp0_result);
      tick();
      rsp0_ready = 1'b1;
      probe();
      checks++; if (rsp0_valid !== 1'b1) begin errors++; $display("FAIL bp_before_release: got %0h expected 1", rsp0_valid); end
      tick();
      rsp0_ready = 1'b0;
      probe();
      checks++; if (rsp0_valid !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept: got v%0b r%0b%0b expected v0 r01", rsp0_valid, req0_ready, req1_ready); end
      tick();
      req1_valid = 1'b0;
      probe();
      tick(); probe();
      checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd15) begin errors++; $display("FAIL bp_req1_rsp: got %0b/%0h expected 1/f", rsp1_valid, rsp1_result); end
      $display("backpressure: rsp1 result=%0h", rsp1_result);
      tick();
      rsp1_ready = 1'b0;
      probe();
      checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL bp_req1_drop: got %0h expected 0", rsp1_valid); end
   endtask

   task automatic test_reset_midop();
      tick();
      req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd4; req0_ctrl = 4'b0010;
      probe();
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rmid_accept: got %0h expected 1", req0_ready); end
      tick();
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b1;
      probe();
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_rst: got %0h expected 0", req1_ready); end
      tick();
      rst = 1'b0; req1_valid = 1'b0;
      probe();
      checks++; if (rsp0_valid !== 1'b0 || alu_a !== 32'd0) begin errors++; $display("FAIL rmid_dropped: got %0b/%0h expected 0/0", rsp0_valid, alu_a); end
      tick(); probe();
      checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp: got %0b%0b expected 00", rsp0_valid, rsp1_valid); end
      tick();
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 4'b0010;
      req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h3C; req1_ctrl = 4'b0000;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      probe();
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rmid_first_tie: got %0b%0b expected 10", req0_ready, req1_ready); end
      tick();
      req0_valid = 1'b0;
      probe();
      tick(); probe();
      checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd2) begin errors++; $display("FAIL rmid_add: got %0b/%0h expected 1/2", rsp0_valid, rsp0_result); end
      $display("after reset: rsp0 result=%0h", rsp0_result);
      tick(); probe();
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rmid_req1_accept: got %0h expected 1", req1_ready); end
      tick();
      req1_valid = 1'b0;
      probe();
      tick(); probe();
      checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h30) begin errors++; $display("FAIL rmid_and: got %0b/%0h expected 1/30", rsp1_valid, rsp1_result); end
      $display("after reset: rsp1 result=%0h", rsp1_result);
      tick();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      probe();
   endtask

   task automatic test_opcheck();
      logic [CTRLW-1:0] exp_ctrl;
      logic             exp_err;
`ifdef ALU_OPCHECK_EN
      exp_ctrl = 4'b0000;
      exp_err  = 1'b1;
`else
      exp_ctrl = 4'b1111;
      exp_err  = 1'b0;
`endif
      tick();
      req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_ctrl = 4'b1111;
      probe();
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL opchk_accept: got %0h expected 1", req0_ready); end
      tick();
      req0_valid = 1'b0;
      probe();
      checks++; if (alu_ctrl !== exp_ctrl) begin errors++; $display("FAIL opchk_alu_ctrl: got %0h expected %0h", alu_ctrl, exp_ctrl); end
      tick();
      rsp0_ready = 1'b1;
      probe();
      checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd0 || rsp0_zero !== 1'b1) begin errors++; $display("FAIL opchk_rsp: got %0b/%0h/%0b expected 1/0/1", rsp0_valid, rsp0_result, rsp0_zero); end
      checks++; if (rsp0_err !== exp_err) begin errors++; $display("FAIL opchk_err: got %0h expected %0h", rsp0_err, exp_err); end
      $display("opcheck: rsp0 result=%0h zero=%0b err=%0b", rsp0_result, rsp0_zero, rsp0_err);
      tick();
      rsp0_ready = 1'b0;
      probe();
      checks++; if (rsp0_valid !== 1'b0 || alu_a !== 32'd9) begin errors++; $display("FAIL opchk_idle_hold: got %0b/%0h expected 0/9", rsp0_valid, alu_a); end
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      test_reset();
      test_single_op();
      test_zero_flag();
      test_contention();
      test_backpressure();
      test_reset_midop();
      test_opcheck();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
